// File: rtl/siphash_pkg.sv
// Shared SipHash constants, controller state encoding and small word helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package siphash_pkg;

  // Initial-state constants ("somepseudorandomlygeneratedbytes").
  localparam logic [63:0] IV0 = 64'h736f6d6570736575;
  localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
  localparam logic [63:0] IV2 = 64'h6c7967656e657261;
  localparam logic [63:0] IV3 = 64'h7465646279746573;

  // Folded into v2 ahead of the first finalisation round.
  localparam logic [63:0] FIN_XOR = 64'hff;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    COMP,
    FIN,
    DONE
  } state_t;

  // Keep the n low bytes of a little-endian word, zero the rest.
  function automatic logic [63:0] mask_bytes(input logic [63:0] w, input logic [3:0] n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n) m[i*8 +: 8] = 8'hff;
    end
    return w & m;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/siphash_ctrl_round.sv
// One combinational SipRound over the four 64-bit state words.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   v0..v3  in  64  state words entering the round
//   n0..n3  out 64  state words leaving the round
module sip_round
  import siphash_pkg::*;
(
  input  logic [63:0] v0,
  input  logic [63:0] v1,
  input  logic [63:0] v2,
  input  logic [63:0] v3,
  output logic [63:0] n0,
  output logic [63:0] n1,
  output logic [63:0] n2,
  output logic [63:0] n3
);

  logic [63:0] a0, a1, a2, a3;
  logic [63:0] b0, b1, b2, b3;

  // First half: two independent add-rotate-xor lanes.
  assign a0 = rotl(v0 + v1, 32);
  assign a1 = rotl(v1, 13) ^ (v0 + v1);
  assign a2 = v2 + v3;
  assign a3 = rotl(v3, 16) ^ (v2 + v3);

  // Second half: lanes cross over (v0 pairs with v3, v2 with v1).
  assign b0 = a0 + a3;
  assign b3 = rotl(a3, 21) ^ b0;
  assign b2 = a2 + a1;
  assign b1 = rotl(a1, 17) ^ b2;

  assign n0 = b0;
  assign n1 = b1;
  assign n2 = rotl(b2, 32);
  assign n3 = b3;

endmodule

// File: rtl/siphash_ctrl.sv
// Iterative SipHash-c-d controller: one SipRound per clock over registered v0..v3.
// Latency: last partial word -> tag in C+D+1 edges; full last word adds C (pad block).
// Backpressure: in_ready only in ABSORB; tag held in DONE until hash_ready.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, key[127:0]              begin hash (IDLE only); k0=key[63:0], k1=key[127:64]
//   busy                           high outside IDLE
//   in_valid/in_ready              message word handshake
//   in_data[63:0], in_bytes[3:0]   little-endian word, valid byte count (last word only)
//   in_last                        final word of message
//   hash_valid/hash_ready, hash    64-bit tag out, stable while hash_valid
module siphash_ctrl
  import siphash_pkg::*;
#(
  parameter int C_ROUNDS = 2,
  parameter int D_ROUNDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [3:0]   in_bytes,
  input  logic         in_last,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [63:0]  hash
);

  localparam int MAX_R = (C_ROUNDS > D_ROUNDS) ? C_ROUNDS : D_ROUNDS;
  localparam int CNT_W = (MAX_R > 1) ? $clog2(MAX_R) : 1;

  state_t             state, state_nxt;
  logic [63:0]        v0, v1, v2, v3;
  logic [63:0]        m_reg;
  logic [7:0]         len;
  logic [CNT_W-1:0]   rnd;
  logic               pad_pend, fin_pend;

  logic [63:0]        r_v2, r_v3;
  logic [63:0]        o_v0, o_v1, o_v2, o_v3;
  logic               accept, last_c, last_f, short_last;
  logic [7:0]         len_tail;

  assign busy     = (state != IDLE);
  assign in_ready = (state == ABSORB);
  assign accept   = in_valid & in_ready;
  assign last_c   = (state == COMP) && (rnd == CNT_W'(C_ROUNDS - 1));
  assign last_f   = (state == FIN)  && (rnd == CNT_W'(D_ROUNDS - 1));

  // A last word carrying fewer than 8 bytes folds the length byte in directly;
  // a full last word needs a separate length-only block afterwards.
  assign short_last = in_last && (in_bytes < 4'd8);
  assign len_tail   = len + {4'b0, in_bytes};

  // Message/finalisation XORs apply only on the first round of each phase.
  assign r_v3 = (state == COMP && rnd == '0) ? (v3 ^ m_reg)   : v3;
  assign r_v2 = (state == FIN  && rnd == '0) ? (v2 ^ FIN_XOR) : v2;

  sip_round u_round (
    .v0 (v0),
    .v1 (v1),
    .v2 (r_v2),
    .v3 (r_v3),
    .n0 (o_v0),
    .n1 (o_v1),
    .n2 (o_v2),
    .n3 (o_v3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = ABSORB;
      ABSORB: if (accept) state_nxt = COMP;
      COMP: begin
        if (last_c) begin
          if (pad_pend)      state_nxt = COMP;
          else if (fin_pend) state_nxt = FIN;
          else               state_nxt = ABSORB;
        end
      end
      FIN:    if (last_f) state_nxt = DONE;
      DONE:   if (hash_valid && hash_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0         <= '0;
      v1         <= '0;
      v2         <= '0;
      v3         <= '0;
      m_reg      <= '0;
      len        <= '0;
      rnd        <= '0;
      pad_pend   <= 1'b0;
      fin_pend   <= 1'b0;
      hash       <= '0;
      hash_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            v0       <= key[63:0]   ^ IV0;
            v1       <= key[127:64] ^ IV1;
            v2       <= key[63:0]   ^ IV2;
            v3       <= key[127:64] ^ IV3;
            len      <= '0;
            rnd      <= '0;
            pad_pend <= 1'b0;
            fin_pend <= 1'b0;
          end
        end
        ABSORB: begin
          if (accept) begin
            rnd <= '0;
            if (short_last) begin
              m_reg    <= {len_tail, 56'b0} | mask_bytes(in_data, in_bytes);
              fin_pend <= 1'b1;
            end else begin
              m_reg    <= in_data;
              len      <= len + 8'd8;
              pad_pend <= in_last;
            end
          end
        end
        COMP: begin
          v0  <= last_c ? (o_v0 ^ m_reg) : o_v0;
          v1  <= o_v1;
          v2  <= o_v2;
          v3  <= o_v3;
          rnd <= last_c ? '0 : rnd + CNT_W'(1);
          if (last_c && pad_pend) begin
            m_reg    <= {len, 56'b0};
            pad_pend <= 1'b0;
            fin_pend <= 1'b1;
          end else if (last_c && fin_pend) begin
            fin_pend <= 1'b0;
          end
        end
        FIN: begin
          v0  <= o_v0;
          v1  <= o_v1;
          v2  <= o_v2;
          v3  <= o_v3;
          rnd <= last_f ? '0 : rnd + CNT_W'(1);
        end
        DONE: begin
          // First DONE cycle captures the tag; it then holds until consumed.
          if (!hash_valid) begin
            hash       <= v0 ^ v1 ^ v2 ^ v3;
            hash_valid <= 1'b1;
          end else if (hash_ready) begin
            hash_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
